datamover_rd_checker: RTL

Self-checking sink for the MM2S read-data stream of the DataMover validation path. It is armed with a byte length and a 64-bit seed, accepts the read-back AXI-Stream beats, and compares each beat against the pattern the write side produced. The pattern is a 64-bit incrementing word, seed+n on beat n. It reports pass/fail, error counts and first-error location, and can throttle `tready` to exercise DataMover backpressure.

---
 rtl/datamover_rd_checker.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/datamover_rd_checker.sv
// datamover_rd_checker: self-checking sink for the MM2S read-back stream.
// Armed with a byte length and a 64-bit seed, it expects beat n to carry
// seed+n. It checks data on kept bytes only, tkeep and tlast placement. It
// reports sticky error flags, counters and the first failing beat, and can
// throttle tready from an LFSR to exercise upstream backpressure.
module datamover_rd_checker #(
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_arm,
    input  logic [15:0] i_length,
    input  logic [63:0] i_seed,
    input  logic        i_bp_en,
    input  logic [63:0] i_mm2s_rd_tdata,
    input  logic [7:0]  i_mm2s_rd_tkeep,
    input  logic        i_mm2s_rd_tvalid,
    input  logic        i_mm2s_rd_tlast,
    output logic        o_mm2s_rd_tready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_err_data,
    output logic        o_err_keep,
    output logic        o_err_last,
    output logic        o_err_timeout,
    output logic        o_err_len,
    output logic [15:0] o_err_cnt,
    output logic [13:0] o_first_err_beat,
    output logic [13:0] o_beat_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          arm_r_q;
    logic          arm_pulse_q;
    logic [16:0]   n_q, n_d;
    logic [7:0]    last_keep_q, last_keep_d;
    logic [63:0]   exp_q, exp_d;
    logic          bp_en_q, bp_en_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [13:0]   beat_cnt_q, beat_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [13:0]   first_err_q, first_err_d;
    logic          err_data_q, err_data_d;
    logic          err_keep_q, err_keep_d;
    logic          err_last_q, err_last_d;
    logic          err_to_q, err_to_d;
    logic          err_len_q, err_len_d;
    logic          pass_q, pass_d;

    logic          tready;
    logic          accept;
    logic [16:0]   idx;
    logic [16:0]   last_idx;
    logic          is_last, is_early, is_drain;
    logic [7:0]    exp_keep;
    logic [7:0]    arm_keep;
    logic          data_bad, keep_bad, last_bad, beat_bad;
    logic          pass_now;

    // Beat classification and comparison for the beat currently on the bus.
    always_comb begin
        tready   = (state_q == S_RUN) && (!bp_en_q || lfsr_q[0]);
        accept   = tready && i_mm2s_rd_tvalid;
        idx      = {3'b000, beat_cnt_q};
        last_idx = n_q - 17'd1;
        is_last  = (idx == last_idx);
        is_early = (idx < last_idx);
        is_drain = (idx > last_idx);
        exp_keep = is_last ? last_keep_q : 8'hFF;
        data_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (exp_keep[i] && (i_mm2s_rd_tdata[8*i +: 8] != exp_q[8*i +: 8])) begin
                data_bad = 1'b1;
            end
        end
        keep_bad = (i_mm2s_rd_tkeep != exp_keep);
        // Drain beats (past N-1) without tlast are errors; the closing tlast beat is not.
        last_bad = (is_early && i_mm2s_rd_tlast) ||
                   (is_last  && !i_mm2s_rd_tlast) ||
                   (is_drain && !i_mm2s_rd_tlast);
        beat_bad = data_bad || keep_bad || last_bad;
        pass_now = !(err_data_q || err_keep_q || err_last_q || err_to_q || err_len_q) &&
                   (idx == n_q);
    end

    // Last-beat keep derived from the armed length: low len[2:0] bytes, or all 8.
    always_comb begin
        arm_keep = 8'h00;
        for (int i = 0; i < 8; i++) begin
            arm_keep[i] = (i_length[2:0] == 3'd0) || (3'(i) < i_length[2:0]);
        end
    end

    // Next-state logic for the check FSM and all result registers.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        last_keep_d = last_keep_q;
        exp_d       = exp_q;
        bp_en_d     = bp_en_q;
        lfsr_d      = lfsr_q;
        idle_d      = idle_q;
        beat_cnt_d  = beat_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_data_d  = err_data_q;
        err_keep_d  = err_keep_q;
        err_last_d  = err_last_q;
        err_to_d    = err_to_q;
        err_len_d   = err_len_q;
        pass_d      = pass_q;

        case (state_q)
            S_IDLE: begin
                if (arm_pulse_q) begin
                    idle_d      = '0;
                    beat_cnt_d  = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    err_data_d  = 1'b0;
                    err_keep_d  = 1'b0;
                    err_last_d  = 1'b0;
                    err_to_d    = 1'b0;
                    pass_d      = 1'b0;
                    lfsr_d      = LFSR_SEED;
                    if (i_length == 16'd0) begin
                        err_len_d = 1'b1;
                        n_d       = '0;
                        state_d   = S_DONE;
                    end else begin
                        err_len_d   = 1'b0;
                        n_d         = ({1'b0, i_length} + 17'd7) >> 3;
                        last_keep_d = arm_keep;
                        exp_d       = i_seed;
                        bp_en_d     = i_bp_en;
                        state_d     = S_RUN;
                    end
                end
            end
            S_RUN: begin
                lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                if (accept) begin
                    idle_d     = '0;
                    exp_d      = exp_q + 64'd1;
                    beat_cnt_d = (beat_cnt_q == 14'h3FFF) ? beat_cnt_q : beat_cnt_q + 14'd1;
                    err_data_d = err_data_q | data_bad;
                    err_keep_d = err_keep_q | keep_bad;
                    err_last_d = err_last_q | last_bad;
                    if (beat_bad) begin
                        err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                        if (err_cnt_q == 16'd0) begin
                            first_err_d = beat_cnt_q;
                        end
                    end
                    if (i_mm2s_rd_tlast) begin
                        state_d = S_DONE;
                    end
                end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_to_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            S_DONE: begin
                pass_d  = pass_now;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            arm_r_q     <= 1'b0;
            arm_pulse_q <= 1'b0;
            n_q         <= '0;
            last_keep_q <= '0;
            exp_q       <= '0;
            bp_en_q     <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            idle_q      <= '0;
            beat_cnt_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_data_q  <= 1'b0;
            err_keep_q  <= 1'b0;
            err_last_q  <= 1'b0;
            err_to_q    <= 1'b0;
            err_len_q   <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_r_q     <= i_arm;
            arm_pulse_q <= i_arm & ~arm_r_q;
            n_q         <= n_d;
            last_keep_q <= last_keep_d;
            exp_q       <= exp_d;
            bp_en_q     <= bp_en_d;
            lfsr_q      <= lfsr_d;
            idle_q      <= idle_d;
            beat_cnt_q  <= beat_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_data_q  <= err_data_d;
            err_keep_q  <= err_keep_d;
            err_last_q  <= err_last_d;
            err_to_q    <= err_to_d;
            err_len_q   <= err_len_d;
            pass_q      <= pass_d;
        end
    end

    // Output mapping; pass is live in the DONE cycle and held afterwards.
    always_comb begin
        o_mm2s_rd_tready = tready;
        o_busy           = (state_q != S_IDLE);
        o_done           = (state_q == S_DONE);
        o_pass           = (state_q == S_DONE) ? pass_now : pass_q;
        o_err_data       = err_data_q;
        o_err_keep       = err_keep_q;
        o_err_last       = err_last_q;
        o_err_timeout    = err_to_q;
        o_err_len        = err_len_q;
        o_err_cnt        = err_cnt_q;
        o_first_err_beat = first_err_q;
        o_beat_cnt       = beat_cnt_q;
    end

endmodule
